dmem_ctrl: RTL
==============

// Module: dmem_ctrl
// PURPOSE
//  Sequences and shares the single-port word-wide data memory (dmem) between two requesters: core LSU (port 0) and DMA/debug (port 1).
//  Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-indexed dmem is_load/is_store cycles; sub-word stores use read-modify-write.
//  Sits between the MEM stage / DMA engine and dmem. One transaction outstanding at a time.
// PARAMETERS
//  ADDR_W   32  byte-address width of requester ports
//  RR_EN    1   1 = round-robin arbitration; 0 = fixed priority, port 0 wins
// PORTS
//  clk          in   1       single clock, all state on posedge; dmem samples on negedge
//  rst          in   1       synchronous, active-high reset
//  c_req_valid  in   1       core request valid; held with fields stable until c_req_ready
//  c_req_ready  out  1       core request accepted (1-cycle pulse)
//  c_req_we     in   1       1 = store, 0 = load
//  c_req_funct3 in   3       size/sign per define.sv: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  c_req_addr   in   ADDR_W  byte address
//  c_req_wdata  in   32      store data, right-aligned
//  c_rsp_valid  out  1       core response pulse (load data or store ack)
//  c_rsp_rdata  out  32      formatted load data, sign/zero-extended; 0 for stores
//  c_rsp_err    out  1       misaligned access, no memory access performed
//  d_*          --   --      DMA port, identical set to c_* (d_req_valid .. d_rsp_err)
//  is_load      out  1       to dmem: read word mem_addr this cycle
//  is_store     out  1       to dmem: write store_data to mem_addr this cycle
//  mem_addr     out  32      to dmem: word index = {2'b00, req_addr[31:2]}
//  store_data   out  32      to dmem: full word to write
//  load_data    in   32      from dmem: valid after the negedge of an is_load cycle
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (core favoured); all *_ready, *_rsp_valid, *_rsp_err, is_load, is_store = 0; rdata/mem_addr/store_data = 0.
//  FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RSP.
//  IDLE: arbitrate among valid requesters; winner gets ready=1 in this cycle; the request is latched (owner, we, funct3, addr, wdata).
//   misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> RSP with err=1; no dmem strobe ever issued.
//   load -> RD; SW -> WR; SB/SH -> RMW_RD. Invalid funct3 (011, 11x) is treated as misaligned.
//  RD: is_load=1; at posedge capture load_data, extract lane by addr[1:0], extend -> RSP.
//  WR: is_store=1, store_data=wdata -> RSP.
//  RMW_RD: is_load=1; capture load_data into merge reg -> RMW_WR.
//  RMW_WR: is_store=1, store_data = old word with byte/half lane replaced by wdata[7:0]/[15:0] -> RSP.
//  RSP: owner's rsp_valid=1 for exactly one cycle with rdata/err; -> IDLE. No request accepted in RSP.
//  Latency, accept-edge to rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
//  is_load/is_store decode combinationally from registered state only, never both high, and are stable across the negedge.
//  Arbitration: both valid with RR_EN=1 -> grant port rr_ptr, then rr_ptr <= ~winner. Single valid -> grant it, rr_ptr <= ~winner. RR_EN=0 -> port 0 always wins.
//  Requester dropping valid before ready: legal, nothing issued. Requester changes fields while waiting: latest values are used.
//  Lane rules: B lane = addr[1:0]; H lane = addr[1]; LB/LH sign-extend; LBU/LHU zero-extend.
//  Reset mid-operation: rst high at a posedge -> IDLE next cycle; pending response is dropped.
//   A WR/RMW_WR cycle whose negedge precedes that posedge has already written; RMW_RD aborted -> memory unchanged.
// STRUCTURE
//  Shared package dmem_ctrl_pkg: state enum; funct3 size constants (shared with define.sv); req_t struct {we, funct3, addr, wdata}.
//  Sub-module dmem_lane_fmt (combinational): load extract/extend and store lane merge, used by RD and RMW_WR.
//  Top holds FSM, arbiter/rr_ptr, request latch, response regs.
// TESTING
//  Reset: rst=1 for 2 cycles with both req_valid=1 -> no ready, no is_load/is_store, all outputs 0.
//  SW 0xDEADBEEF @0x1000, then LW @0x1000 (core) -> is_store once with mem_addr=0x400; LW rsp 0xDEADBEEF after 2 cycles.
//  Word=0x11223344 @0x1000: LB @0x1003 -> 0x00000011; LH @0x1002 = 0x00001122; mem 0x8899AABB: LB @0x1000 -> 0xFFFFFFBB, LBU -> 0x000000BB.
//  SB 0xA5 @0x1001 over 0x11223344 -> is_load then is_store, word = 0x1122A544; rsp 3 cycles after accept.
//  LW @0x1002 and SH @0x1001 -> rsp_err=1 after 1 cycle; is_load/is_store never asserted.
//  Both ports valid continuously for 4 txns -> grants core,dma,core,dma; with RR_EN=0 core only.
//  rst pulsed in RMW_RD of an SB -> word unchanged, no rsp_valid, next request served normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller: FSM states,
// funct3 size codes and the latched request record.
package dmem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RSP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Undefined size codes are rejected the same way as a misaligned access.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return a[0];
            F3_W:        return (a != 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane logic: extracts and extends a load lane from a word, and
// merges a byte/half store into an existing word.
module dmem_lane_fmt
    import dmem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        if (funct3_i[1:0] == 2'b00) begin
            merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (lane_i[1]) begin
            merge_o[31:16] = wdata_i[15:0];
        end else begin
            merge_o[15:0] = wdata_i[15:0];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port arbiter and sequencer in front of a single-port word-wide data
// memory; sub-word stores are performed as read-modify-write.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_we,
    input  logic [2:0]        c_req_funct3,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic [31:0]       c_req_wdata,
    output logic              c_rsp_valid,
    output logic [31:0]       c_rsp_rdata,
    output logic              c_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [2:0]        d_req_funct3,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata,
    output logic              d_rsp_err,
    output logic              is_load,
    output logic              is_store,
    output logic [31:0]       mem_addr,
    output logic [31:0]       store_data,
    input  logic [31:0]       load_data
);

    state_e      state_q, state_d;
    logic        rr_ptr_q;
    logic        owner_q;
    req_t        req_q;
    logic        err_q;
    logic [31:0] data_q;
    logic        c_rsp_valid_q, d_rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        grant;
    logic        winner;
    req_t        sel_req;
    logic [31:0] fmt_load, fmt_merge;

    // Winner is 0 for the core and 1 for DMA; rr_ptr names the port favoured on a tie.
    always_comb begin
        grant  = (state_q == ST_IDLE) && !rst && (c_req_valid || d_req_valid);
        winner = (c_req_valid && d_req_valid) ? (RR_EN ? rr_ptr_q : 1'b0) : d_req_valid;
        if (winner) begin
            sel_req.we     = d_req_we;
            sel_req.funct3 = d_req_funct3;
            sel_req.addr   = 32'(d_req_addr);
            sel_req.wdata  = d_req_wdata;
        end else begin
            sel_req.we     = c_req_we;
            sel_req.funct3 = c_req_funct3;
            sel_req.addr   = 32'(c_req_addr);
            sel_req.wdata  = c_req_wdata;
        end
    end

    assign c_req_ready = grant && !winner;
    assign d_req_ready = grant && winner;

    dmem_lane_fmt u_fmt (
        .funct3_i (req_q.funct3),
        .lane_i   (req_q.addr[1:0]),
        .word_i   ((state_q == ST_RD) ? load_data : data_q),
        .wdata_i  (req_q.wdata),
        .load_o   (fmt_load),
        .merge_o  (fmt_merge)
    );

    always_comb begin
        state_d    = state_q;
        is_load    = 1'b0;
        is_store   = 1'b0;
        store_data = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    if (misaligned(sel_req.funct3, sel_req.addr[1:0])) state_d = ST_RSP;
                    else if (!sel_req.we)                             state_d = ST_RD;
                    else if (sel_req.funct3[1:0] == 2'b10)            state_d = ST_WR;
                    else                                              state_d = ST_RMW_RD;
                end
            end
            ST_RD: begin
                is_load = 1'b1;
                state_d = ST_RSP;
            end
            ST_WR: begin
                is_store   = 1'b1;
                store_data = req_q.wdata;
                state_d    = ST_RSP;
            end
            ST_RMW_RD: begin
                is_load = 1'b1;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                is_store   = 1'b1;
                store_data = fmt_merge;
                state_d    = ST_RSP;
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr = {2'b00, req_q.addr[31:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= 1'b0;
            owner_q       <= 1'b0;
            req_q         <= '0;
            err_q         <= 1'b0;
            data_q        <= 32'h0;
            c_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            c_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            if (grant) begin
                req_q    <= sel_req;
                owner_q  <= winner;
                rr_ptr_q <= ~winner;
                err_q    <= misaligned(sel_req.funct3, sel_req.addr[1:0]);
            end
            if (state_q == ST_RD)     data_q <= fmt_load;
            if (state_q == ST_RMW_RD) data_q <= load_data;
            if (state_q == ST_RSP) begin
                c_rsp_valid_q <= !owner_q;
                d_rsp_valid_q <= owner_q;
                rsp_rdata_q   <= (req_q.we || err_q) ? 32'h0 : data_q;
                rsp_err_q     <= err_q;
            end
        end
    end

    // Response data and error are shown only on the port that owns the pulse.
    assign c_rsp_valid = c_rsp_valid_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign c_rsp_rdata = c_rsp_valid_q ? rsp_rdata_q : 32'h0;
    assign d_rsp_rdata = d_rsp_valid_q ? rsp_rdata_q : 32'h0;
    assign c_rsp_err   = c_rsp_valid_q & rsp_err_q;
    assign d_rsp_err   = d_rsp_valid_q & rsp_err_q;

endmodule
